// File: rtl/reg64_unpack.sv
// reg64_unpack: takes one IN_W-bit word over a valid/ready handshake and
// streams it out as OUT_W-bit beats, least-significant beat first.
// Optional feature macro: REG64_UNPACK_PARITY_EN adds out_par = ^out_data
// (0 while idle or in reset).
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1; a source holding valid keeps its data stable until that edge, and
// ready may depend combinationally on the downstream ready.
module reg64_unpack #(
    parameter int IN_W  = 64,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
`ifdef REG64_UNPACK_PARITY_EN
    output logic             out_par,
`endif
    output logic             busy
);

    localparam int BEATS = IN_W / OUT_W;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_beat;
    logic [IN_W-1:0]  r_hold;
    logic             w_last;
    logic             w_accept;
    logic             w_xfer;
    logic [OUT_W-1:0] w_beat_data;

    assign w_last   = (r_beat == CW'(BEATS - 1));
    assign w_xfer   = (r_state == S_BUSY) && out_ready;
    assign w_accept = in_valid && in_ready;

    // State register; reset drops any word in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: enter BUSY on accept, leave only after the last beat with no reload.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = S_BUSY;
            S_BUSY: if (w_xfer && w_last && !w_accept) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Hold register and beat counter: hold written only on accept, beat stops at BEATS-1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hold <= '0;
            r_beat <= '0;
        end else if (w_accept) begin
            r_hold <= in_data;
            r_beat <= '0;
        end else if (w_xfer && !w_last) begin
            r_beat <= r_beat + CW'(1);
        end
    end

    // Beat selection from the hold register.
    always_comb begin
        w_beat_data = '0;
        for (int b = 0; b < BEATS; b++) begin
            if (r_beat == CW'(b)) w_beat_data = r_hold[b*OUT_W +: OUT_W];
        end
    end

    // Outputs: ready is combinational from out_ready so words can follow with no bubble.
    always_comb begin
        busy      = (r_state == S_BUSY);
        out_valid = busy;
        out_last  = busy && w_last;
        out_data  = w_beat_data;
        in_ready  = reset && ((r_state == S_IDLE) ||
                              ((r_state == S_BUSY) && w_last && out_ready));
`ifdef REG64_UNPACK_PARITY_EN
        out_par   = busy && (^w_beat_data);
`endif
    end

endmodule

// File: tb/tb_reg64_unpack.sv
// Bench for reg64_unpack: directed vectors, a queue model of the beat stream,
// and literal checks at the key cycles.
module tb_reg64_unpack;

    localparam int IN_W  = 64;
    localparam int OUT_W = 32;
    localparam int BEATS = IN_W / OUT_W;

    logic             clk;
    logic             reset;
    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;
    logic             busy;
`ifdef REG64_UNPACK_PARITY_EN
    logic             out_par;
`endif

    int n_vec;
    int n_err;

    // expected beats: bit OUT_W is the "last" flag, low bits the data
    logic [OUT_W:0] exp_q[$];

    reg64_unpack #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
`ifdef REG64_UNPACK_PARITY_EN
        .out_par   (out_par),
`endif
        .busy      (busy)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // model: check outputs every cycle, then advance the model by this cycle's handshakes
    always @(negedge clk) begin
        logic exp_valid;
        logic exp_in_ready;
        logic [OUT_W-1:0] par_word;
        if (!reset) begin
            chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
            chk("rst_busy",      {63'd0, busy},      64'd0);
            chk("rst_in_ready",  {63'd0, in_ready},  64'd0);
            chk("rst_out_data",  {32'd0, out_data},  64'd0);
            exp_q.delete();
        end else begin
            exp_valid    = (exp_q.size() != 0);
            exp_in_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
            chk("m_out_valid", {63'd0, out_valid}, {63'd0, exp_valid});
            chk("m_busy",      {63'd0, busy},      {63'd0, exp_valid});
            chk("m_in_ready",  {63'd0, in_ready},  {63'd0, exp_in_ready});
            if (exp_valid) begin
                chk("m_out_data", {32'd0, out_data}, {32'd0, exp_q[0][OUT_W-1:0]});
                chk("m_out_last", {63'd0, out_last}, {63'd0, exp_q[0][OUT_W]});
            end
`ifdef REG64_UNPACK_PARITY_EN
            par_word = exp_valid ? exp_q[0][OUT_W-1:0] : '0;
            chk("m_out_par", {63'd0, out_par}, {63'd0, ^par_word});
`else
            par_word = '0;
`endif
            if (exp_valid && out_ready) void'(exp_q.pop_front());
            if (in_valid && exp_in_ready) begin
                for (int b = 0; b < BEATS; b++)
                    exp_q.push_back({(b == BEATS - 1), in_data[b*OUT_W +: OUT_W]});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "timeout");
    end

    initial begin
        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();

        // 1: single word, no backpressure
        in_data = 64'h1122334455667788; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk); chk("t1_in_ready_idle", {63'd0, in_ready}, 64'd1);
        step(); in_valid = 1'b0;
        @(negedge clk);
        chk("t1_beat0", {32'd0, out_data}, 64'h55667788);
        chk("t1_last0", {63'd0, out_last}, 64'd0);
        step();
        @(negedge clk);
        chk("t1_beat1", {32'd0, out_data}, 64'h11223344);
        chk("t1_last1", {63'd0, out_last}, 64'd1);
        chk("t1_in_ready_last", {63'd0, in_ready}, 64'd1);
        step();
        @(negedge clk);
        chk("t1_idle_valid", {63'd0, out_valid}, 64'd0);
        chk("t1_idle_busy",  {63'd0, busy},      64'd0);

        // 2: backpressure on beat0 for 3 cycles
        step();
        in_data = 64'h1122334455667788; in_valid = 1'b1; out_ready = 1'b0;
        step(); in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t2_hold_data",  {32'd0, out_data}, 64'h55667788);
            chk("t2_hold_valid", {63'd0, out_valid}, 64'd1);
            chk("t2_hold_rdy",   {63'd0, in_ready}, 64'd0);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk); chk("t2_release_beat0", {32'd0, out_data}, 64'h55667788);
        step();
        @(negedge clk); chk("t2_beat1", {32'd0, out_data}, 64'h11223344);
        step();
        step();

        // 3: back-to-back words, no bubble
        in_data = 64'hAAAA_0001_BBBB_0002; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_data = 64'hCCCC_0003_DDDD_0004;
        @(negedge clk);
        chk("t3_b0", {32'd0, out_data}, 64'hBBBB0002);
        chk("t3_b0_rdy", {63'd0, in_ready}, 64'd0);
        step();
        @(negedge clk);
        chk("t3_b1", {32'd0, out_data}, 64'hAAAA0001);
        chk("t3_b1_rdy", {63'd0, in_ready}, 64'd1);
        step(); in_valid = 1'b0;
        @(negedge clk);
        chk("t3_b2", {32'd0, out_data}, 64'hDDDD0004);
        chk("t3_b2_valid", {63'd0, out_valid}, 64'd1);
        step();
        @(negedge clk);
        chk("t3_b3", {32'd0, out_data}, 64'hCCCC0003);
        chk("t3_b3_last", {63'd0, out_last}, 64'd1);
        step();
        step();

        // 5: new word offered during beat0 is held off until beat1
        in_data = 64'h1122334455667788; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_data = 64'h0000000F_000000F0;
        @(negedge clk);
        chk("t5_b0_rdy",  {63'd0, in_ready}, 64'd0);
        chk("t5_b0_data", {32'd0, out_data}, 64'h55667788);
        step();
        @(negedge clk);
        chk("t5_b1_data", {32'd0, out_data}, 64'h11223344);
        chk("t5_b1_rdy",  {63'd0, in_ready}, 64'd1);
        step(); in_valid = 1'b0;
        @(negedge clk); chk("t5_w2_b0", {32'd0, out_data}, 64'h000000F0);
        step();
        @(negedge clk); chk("t5_w2_b1", {32'd0, out_data}, 64'h0000000F);
        step();
        step();

        // 4: reset asserted after beat0, then a fresh word
        in_data = 64'h1122334455667788; in_valid = 1'b1; out_ready = 1'b1;
        step(); in_valid = 1'b0;
        step();
        reset = 1'b0;
        #1;
        chk("t4_async_valid", {63'd0, out_valid}, 64'd0);
        chk("t4_async_busy",  {63'd0, busy},      64'd0);
        chk("t4_async_data",  {32'd0, out_data},  64'd0);
        chk("t4_async_rdy",   {63'd0, in_ready},  64'd0);
        step();
        step();
        reset = 1'b1;
        step();
        @(negedge clk); chk("t4_no_resume", {63'd0, out_valid}, 64'd0);
        step();
        in_data = 64'h0000000F_000000F0; in_valid = 1'b1;
        step(); in_valid = 1'b0;
        @(negedge clk); chk("t4_b0", {32'd0, out_data}, 64'h000000F0);
        step();
        @(negedge clk); chk("t4_b1", {32'd0, out_data}, 64'h0000000F);
        step();
        step();

        // 6: parity word
        in_data = 64'h00000003_00000001; in_valid = 1'b1; out_ready = 1'b1;
        step(); in_valid = 1'b0;
        @(negedge clk);
        chk("t6_b0", {32'd0, out_data}, 64'h00000001);
`ifdef REG64_UNPACK_PARITY_EN
        chk("t6_par0", {63'd0, out_par}, 64'd1);
`endif
        step();
        @(negedge clk);
        chk("t6_b1", {32'd0, out_data}, 64'h00000003);
`ifdef REG64_UNPACK_PARITY_EN
        chk("t6_par1", {63'd0, out_par}, 64'd0);
`endif
        step();
        step();

        chk("model_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
